// File: rtl/riscv_state_pkg.sv
// Shared types for the IF redirect arbiter.
// Source encoding doubles as priority: compare numerically.
package riscv_state_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PD   = 2'd1,
    SRC_BU   = 2'd2,
    SRC_ST   = 2'd3
  } redirect_src_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/riscv_if_redirect_arb.sv
// Next-PC redirect arbiter in front of instruction fetch.
// ST > BU > PD, one held redirect, PD squash after flushes.
module riscv_if_redirect_arb
  import riscv_state_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] PC_INIT       = 'h200,
  parameter int              HAS_RVC       = 0,
  parameter int              SQUASH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            st_flush_i,
  input  logic [XLEN-1:0] st_nxt_pc_i,
  input  logic            bu_flush_i,
  input  logic [XLEN-1:0] bu_nxt_pc_i,
  input  logic            pd_latch_nxt_pc_i,
  input  logic [XLEN-1:0] pd_nxt_pc_i,
  input  logic            du_mode_i,
  input  logic            if_ready_i,
  output logic            if_redirect_o,
  output logic [XLEN-1:0] if_redirect_pc_o,
  output redirect_src_t   if_redirect_src_o,
  output logic            pd_drop_o,
  output logic            busy_o
);

  localparam logic [XLEN-1:0] ADR_MASK =
    (HAS_RVC != 0) ? ({XLEN{1'b1}} << 1)
                   : ({XLEN{1'b1}} << 2);

  localparam int SQW =
    (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

  localparam logic [SQW-1:0] SQ_LOAD = SQW'(SQUASH_CYCLES);

  arb_state_t      state;
  redirect_src_t   pend_src;
  logic [XLEN-1:0] pend_pc;
  logic [SQW-1:0]  sq_cnt;

  redirect_src_t   new_src;
  logic [XLEN-1:0] new_pc;
  redirect_src_t   cand_src;
  logic [XLEN-1:0] cand_pc;
  logic            cand_new;
  logic            pd_ok;
  logic            pd_lost;
  logic            flush_evt;
  logic            fire;

  assign pd_ok = pd_latch_nxt_pc_i & ~du_mode_i
               & (sq_cnt == '0);

  // Pick this cycle's new event by fixed priority
  always_comb begin
    new_src = SRC_NONE;
    new_pc  = '0;
    unique case (1'b1)
      st_flush_i: begin
        new_src = SRC_ST;
        new_pc  = st_nxt_pc_i;
      end
      (~st_flush_i & bu_flush_i): begin
        new_src = SRC_BU;
        new_pc  = bu_nxt_pc_i;
      end
      (~st_flush_i & ~bu_flush_i & pd_ok): begin
        new_src = SRC_PD;
        new_pc  = pd_nxt_pc_i;
      end
      default: begin
        new_src = SRC_NONE;
        new_pc  = '0;
      end
    endcase
  end

  // New event wins over the held one at equal or higher priority
  always_comb begin
    cand_new = (new_src != SRC_NONE)
             & (new_src >= pend_src);
    cand_src = cand_new ? new_src : pend_src;
    cand_pc  = cand_new ? new_pc  : pend_pc;
  end

  assign fire      = (cand_src != SRC_NONE) & if_ready_i;
  assign flush_evt = (new_src == SRC_ST) | (new_src == SRC_BU);
  assign pd_lost   = pd_latch_nxt_pc_i
                   & ~(cand_new & (new_src == SRC_PD));

  // Hold/issue FSM with registered IF-side outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= ST_IDLE;
      pend_src          <= SRC_NONE;
      pend_pc           <= '0;
      if_redirect_o     <= 1'b0;
      if_redirect_pc_o  <= PC_INIT & ADR_MASK;
      if_redirect_src_o <= SRC_NONE;
      pd_drop_o         <= 1'b0;
    end else begin
      if_redirect_o <= fire;
      pd_drop_o     <= pd_lost;
      if (fire) begin
        if_redirect_pc_o  <= cand_pc & ADR_MASK;
        if_redirect_src_o <= cand_src;
      end
      unique case (state)
        ST_IDLE: begin
          if ((cand_src != SRC_NONE) && !if_ready_i) begin
            pend_src <= cand_src;
            pend_pc  <= cand_pc;
            state    <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (if_ready_i) begin
            pend_src <= SRC_NONE;
            state    <= ST_IDLE;
          end else begin
            pend_src <= cand_src;
            pend_pc  <= cand_pc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Refill window: ignore PD predictions right after a flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sq_cnt <= '0;
    end else if (flush_evt) begin
      sq_cnt <= SQ_LOAD;
    end else if (sq_cnt != '0) begin
      sq_cnt <= sq_cnt - 1'b1;
    end
  end

  assign busy_o = (state == ST_PEND);

endmodule

// File: tb/tb_riscv_if_redirect_arb.sv
// Bench for riscv_if_redirect_arb: directed scenarios with literal
// expectations, then random traffic against a priority-queue model.
module tb_riscv_if_redirect_arb;

  localparam int SQ = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st = 1'b0, bu = 1'b0, pd = 1'b0;
  logic        du = 1'b0, rdy = 1'b0;
  logic [31:0] st_pc = '0, bu_pc = '0, pd_pc = '0;
  logic        red, drop, busy;
  logic [31:0] rpc;
  logic [1:0]  rsrc;

  int errors = 0;
  int checks = 0;

  riscv_if_redirect_arb #(
    .XLEN(32), .PC_INIT(32'h200),
    .HAS_RVC(0), .SQUASH_CYCLES(SQ)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .st_flush_i        (st),
    .st_nxt_pc_i       (st_pc),
    .bu_flush_i        (bu),
    .bu_nxt_pc_i       (bu_pc),
    .pd_latch_nxt_pc_i (pd),
    .pd_nxt_pc_i       (pd_pc),
    .du_mode_i         (du),
    .if_ready_i        (rdy),
    .if_redirect_o     (red),
    .if_redirect_pc_o  (rpc),
    .if_redirect_src_o (rsrc),
    .pd_drop_o         (drop),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Model: a single held request (priority 0 = none), a flush
  // countdown, and the outputs IF must see after each edge.
  int          m_sq, m_hp, m_src;
  logic [31:0] m_hpc, m_pc;
  logic        m_red, m_drop;
  int          n_p, b_p;
  logic [31:0] n_pc, b_pc;
  bit          took;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sq = 0; m_hp = 0; m_hpc = 0;
      m_red = 0; m_drop = 0;
      m_pc = 32'h200; m_src = 0;
    end else begin
      n_p = 0; n_pc = 0;
      if (st) begin n_p = 3; n_pc = st_pc; end
      else if (bu) begin n_p = 2; n_pc = bu_pc; end
      else if (pd && !du && m_sq == 0) begin
        n_p = 1; n_pc = pd_pc;
      end
      b_p = m_hp; b_pc = m_hpc; took = 0;
      if (n_p != 0 && n_p >= b_p) begin
        b_p = n_p; b_pc = n_pc; took = 1;
      end
      m_drop = pd && !(took && n_p == 1);
      m_red = 0;
      if (b_p != 0 && rdy) begin
        m_red = 1;
        m_pc  = b_pc & 32'hFFFF_FFFC;
        m_src = b_p;
        m_hp  = 0;
      end else if (b_p != 0) begin
        m_hp = b_p; m_hpc = b_pc;
      end
      if (n_p >= 2) m_sq = SQ;
      else if (m_sq > 0) m_sq = m_sq - 1;
    end
  end

  // Every cycle out of reset, the DUT must match the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_redirect", red, m_red);
      chk("m_pd_drop", drop, m_drop);
      chk("m_busy", busy, (m_hp != 0));
      chk("m_src", rsrc, m_src);
      chk("m_pc", rpc, m_pc);
    end
  end

  task automatic cyc(input logic s, input logic [31:0] sp,
                     input logic b, input logic [31:0] bp,
                     input logic p, input logic [31:0] pp,
                     input logic d, input logic r);
    st = s; st_pc = sp;
    bu = b; bu_pc = bp;
    pd = p; pd_pc = pp;
    du = d; rdy = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_redirect", red, 0);
    chk("rst_pc", rpc, 32'h200);
    chk("rst_src", rsrc, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(1);

    // priority: ST beats BU and PD in the same cycle
    cyc(1, 32'h1000, 1, 32'h2000, 1, 32'h3000, 0, 1);
    chk("prio_red", red, 1);
    chk("prio_pc", rpc, 32'h1000);
    chk("prio_src", rsrc, 3);
    chk("prio_drop", drop, 1);

    // hold: BU waits three cycles for IF
    cyc(0, 0, 1, 32'h2000, 0, 0, 0, 0);
    chk("hold_busy1", busy, 1);
    chk("hold_red1", red, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("hold_busy2", busy, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("hold_busy3", busy, 1);
    chk("hold_red3", red, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("hold_red", red, 1);
    chk("hold_pc", rpc, 32'h2000);
    chk("hold_src", rsrc, 2);
    chk("hold_busy_off", busy, 0);
    idle(1);
    chk("hold_single", red, 0);
    idle(2);

    // override: pending PD displaced by a later BU
    cyc(0, 0, 0, 0, 1, 32'h3000, 0, 0);
    chk("ovr_busy", busy, 1);
    chk("ovr_drop0", drop, 0);
    cyc(0, 0, 1, 32'h2004, 0, 0, 0, 0);
    chk("ovr_red0", red, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("ovr_red", red, 1);
    chk("ovr_pc", rpc, 32'h2004);
    chk("ovr_src", rsrc, 2);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("ovr_no_pd", red, 0);
    end

    // squash window after a BU flush
    cyc(0, 0, 1, 32'h4000, 0, 0, 0, 1);
    chk("sq_bu", red, 1);
    cyc(0, 0, 0, 0, 1, 32'h5000, 0, 1);
    chk("sq_drop1", drop, 1);
    chk("sq_red1", red, 0);
    cyc(0, 0, 0, 0, 1, 32'h5004, 0, 1);
    chk("sq_drop2", drop, 1);
    chk("sq_red2", red, 0);
    cyc(0, 0, 0, 0, 1, 32'h5008, 0, 1);
    chk("sq_red3", red, 1);
    chk("sq_pc3", rpc, 32'h5008);
    chk("sq_src3", rsrc, 1);
    chk("sq_drop3", drop, 0);

    // address mask and debug-mode PD drop
    cyc(1, 32'h1003, 0, 0, 0, 0, 0, 1);
    chk("mask_pc", rpc, 32'h1000);
    idle(3);
    cyc(0, 0, 0, 0, 1, 32'h6000, 1, 1);
    chk("du_red", red, 0);
    chk("du_drop", drop, 1);

    // reset while a redirect is held
    idle(1);
    cyc(0, 0, 1, 32'h7000, 0, 0, 0, 0);
    chk("mid_busy", busy, 1);
    st = 0; bu = 0; pd = 0; du = 0; rdy = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_red", red, 0);
    chk("mid_rst_pc", rpc, 32'h200);
    chk("mid_rst_src", rsrc, 0);
    chk("mid_rst_drop", drop, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_red", red, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pc", rpc, 32'h200);

    // random traffic, one async reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      cyc(($urandom % 12) == 0, $urandom,
          ($urandom % 7) == 0, $urandom,
          ($urandom % 3) == 0, $urandom,
          ($urandom % 10) == 0,
          ($urandom % 100) < 65);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
